mode_register: RTL and testbench
================================

MODE_REGISTER -- requirements
Module: mode_register

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits (legal range 2..32).
REQ-002 SHALL have parameter RESET_VALUE, default 0, value loaded into q by reset (WIDTH bits).
REQ-003 SHALL have parameter WRAP, default 1: 1 means inc/dec wrap modulo 2^WIDTH; 0 means inc/dec saturate.
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port nclr, input, 1, reset: asynchronous, active-low.
REQ-006 SHALL have port en, input, 1, operation enable, sampled on the rising edge of clk.
REQ-007 SHALL have port mode, input, 3, operation select, sampled on the rising edge of clk.
REQ-008 SHALL have port d, input, WIDTH, parallel load data.
REQ-009 SHALL have port sin, input, 1, serial input bit for shift modes.
REQ-010 SHALL have port q, output, WIDTH, registered contents.
REQ-011 SHALL have port cout, output, 1, registered carry/borrow/shifted-out flag.
REQ-012 SHALL have port zero, output, 1, combinational flag that is high when q equals 0.

Function
REQ-013 SHALL update q and cout only on a rising clk edge with en=1 and nclr=1; with en=0, q and cout SHALL hold.
REQ-014 SHALL decode mode as follows: 000 hold; 001 load (q<=d); 010 inc; 011 dec; 100 shl (q<={q[W-2:0],sin}); 101 shr (q<={sin,q[W-1:1]}); 110 rotl (q<={q[W-2:0],q[W-1]}); 111 sync clear (q<=0).
REQ-015 SHALL have zero latency beyond one edge: the new q is visible after the same rising edge that samples en/mode/d/sin.
REQ-016 For inc with WRAP=1, SHALL set q<=q+1 mod 2^WIDTH, with cout<=1 only when the old q was all ones, else 0.
REQ-017 For dec with WRAP=1, SHALL set q<=q-1 mod 2^WIDTH, with cout<=1 only when the old q was 0, else 0.
REQ-018 For inc with WRAP=0 and old q all ones, SHALL keep q all ones and set cout<=1; below max, SHALL behave as REQ-016 with cout<=0.
REQ-019 For dec with WRAP=0 and old q=0, SHALL keep q=0 and set cout<=1; above 0, SHALL behave as REQ-017 with cout<=0.
REQ-020 For shl and rotl, SHALL set cout<=old q[WIDTH-1]; for shr, SHALL set cout<=old q[0].
REQ-021 For hold, load and sync clear with en=1, SHALL set cout<=0; hold SHALL leave q unchanged.
REQ-022 SHALL derive zero from the registered q only, never from d or mode, so that it is glitch-free with respect to inputs.
REQ-023 SHALL ignore d for every mode except load, and sin for every mode except shl/shr.

Reset
REQ-024 While nclr=0, SHALL force q=RESET_VALUE and cout=0 immediately, independent of clk, en and mode.
REQ-025 SHALL give nclr precedence over all clocked operations, including an edge that coincides with assertion.
REQ-026 SHALL produce no change on the deassertion of nclr itself; the first rising clk edge with nclr=1 SHALL perform the operation selected at that edge.
REQ-027 SHALL be fully defined after reset, with no X on q, cout or zero.

Verification
REQ-028 Bench SHALL cover: WIDTH=8, load 0xFE, two inc edges -> q=0xFF with cout=0, then q=0x00 with cout=1 and zero=1.
REQ-029 Bench SHALL cover: WIDTH=8, WRAP=0, q=0x00, dec -> q=0x00 and cout=1; a following load of 0x01 -> cout=0.
REQ-030 Bench SHALL cover: q=0x81, shl with sin=0 -> q=0x02, cout=1; then shr with sin=1 -> q=0x81, cout=0; then rotl -> q=0x03, cout=1.
REQ-031 Bench SHALL cover: en=0 with every mode value across 8 edges -> q and cout unchanged.
REQ-032 Bench SHALL cover: RESET_VALUE=0x5A, nclr pulsed low mid-cycle during a run of inc -> q=0x5A immediately without any clock edge; the first edge after release with mode=inc -> q=0x5B.
REQ-033 Bench SHALL cover: mode=111 with q=0x3C -> q=0x00, zero=1, cout=0.

Source files
------------

// File: rtl/mode_register.sv
// Multi-mode register: load, wrap/saturating inc/dec, shifts, rotate and sync clear.
// cout carries the carry, borrow or bit shifted out by the last enabled operation.
module mode_register #(
    parameter int WIDTH       = 8,
    parameter int RESET_VALUE = 0,
    parameter int WRAP        = 1
) (
    input  logic             clk,
    input  logic             nclr,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             cout,
    output logic             zero
);

    localparam logic [WIDTH-1:0] RST  = WIDTH'(RESET_VALUE);
    localparam logic [WIDTH-1:0] ONES = '1;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_LOAD = 3'b001;
    localparam logic [2:0] M_INC  = 3'b010;
    localparam logic [2:0] M_DEC  = 3'b011;
    localparam logic [2:0] M_SHL  = 3'b100;
    localparam logic [2:0] M_SHR  = 3'b101;
    localparam logic [2:0] M_ROTL = 3'b110;
    localparam logic [2:0] M_CLR  = 3'b111;

    logic [WIDTH-1:0] q_nxt;
    logic             c_nxt;

    always_comb begin
        q_nxt = q;
        c_nxt = 1'b0;
        case (mode)
            M_HOLD: q_nxt = q;
            M_LOAD: q_nxt = d;
            M_INC: begin
                // At the top, wrap to zero or stick at max; either way flag it.
                if (q == ONES) begin
                    q_nxt = (WRAP != 0) ? '0 : ONES;
                    c_nxt = 1'b1;
                end else begin
                    q_nxt = q + ONE;
                end
            end
            M_DEC: begin
                if (q == '0) begin
                    q_nxt = (WRAP != 0) ? ONES : '0;
                    c_nxt = 1'b1;
                end else begin
                    q_nxt = q - ONE;
                end
            end
            M_SHL: begin
                q_nxt = {q[WIDTH-2:0], sin};
                c_nxt = q[WIDTH-1];
            end
            M_SHR: begin
                q_nxt = {sin, q[WIDTH-1:1]};
                c_nxt = q[0];
            end
            M_ROTL: begin
                q_nxt = {q[WIDTH-2:0], q[WIDTH-1]};
                c_nxt = q[WIDTH-1];
            end
            M_CLR:   q_nxt = '0;
            default: q_nxt = q;
        endcase
    end

    always_ff @(posedge clk or negedge nclr) begin
        if (!nclr) begin
            q    <= RST;
            cout <= 1'b0;
        end else if (en) begin
            q    <= q_nxt;
            cout <= c_nxt;
        end
    end

    // Derived from the register alone so it never glitches on d/mode changes.
    assign zero = (q == '0);

endmodule

// File: tb/tb_mode_register.sv
// Bench for mode_register: a wrapping instance (RESET_VALUE=0x5A) and a saturating
// instance share all inputs and are checked against a table and an arithmetic model.
module tb_mode_register;

    logic       clk = 1'b0;
    logic       nclr;
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sin;

    logic [7:0] qw, qs;
    logic       cw, cs, zw, zs;

    int checks = 0;
    int errors = 0;

    // Reference state, one per instance.
    int mq_w, mc_w, mq_s, mc_s;

    always #5 clk = ~clk;

    mode_register #(.WIDTH(8), .RESET_VALUE(8'h5A), .WRAP(1)) dut_w (
        .clk(clk), .nclr(nclr), .en(en), .mode(mode), .d(d), .sin(sin),
        .q(qw), .cout(cw), .zero(zw));

    mode_register #(.WIDTH(8), .RESET_VALUE(0), .WRAP(0)) dut_s (
        .clk(clk), .nclr(nclr), .en(en), .mode(mode), .d(d), .sin(sin),
        .q(qs), .cout(cs), .zero(zs));

    typedef struct {
        logic       en;
        logic [2:0] mode;
        logic [7:0] d;
        logic       sin;
        logic [7:0] q;
        logic       c;
        logic       z;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Next state from the operation rules, using plain integer arithmetic.
    task automatic model(input int wrap, input int q, input int e, input int m,
                         input int dv, input int s, inout int nq, inout int nc);
        if (e == 0) return;
        nq = q;
        nc = 0;
        case (m)
            0: ;
            1: nq = dv;
            2: if (q == 255) begin nq = wrap ? 0 : 255; nc = 1; end else nq = q + 1;
            3: if (q == 0) begin nq = wrap ? 255 : 0; nc = 1; end else nq = q - 1;
            4: begin nc = q / 128; nq = (q * 2 + s) % 256; end
            5: begin nc = q % 2;   nq = q / 2 + s * 128; end
            6: begin nc = q / 128; nq = (q * 2) % 256 + q / 128; end
            default: nq = 0;
        endcase
    endtask

    task automatic check_model(input string tag);
        check({tag, "_q_wrap"}, qw, mq_w);
        check({tag, "_c_wrap"}, cw, mc_w);
        check({tag, "_z_wrap"}, zw, (mq_w == 0));
        check({tag, "_q_sat"},  qs, mq_s);
        check({tag, "_c_sat"},  cs, mc_s);
        check({tag, "_z_sat"},  zs, (mq_s == 0));
    endtask

    // Drive inputs mid-cycle, take one edge, advance the model, compare #1 later.
    task automatic cyc(input logic e, input logic [2:0] m, input logic [7:0] dv,
                       input logic s, input string tag);
        int ow, os;
        en = e; mode = m; d = dv; sin = s;
        @(posedge clk);
        ow = mq_w; os = mq_s;
        model(1, ow, e, m, dv, s, mq_w, mc_w);
        model(0, os, e, m, dv, s, mq_s, mc_s);
        #1;
        check_model(tag);
    endtask

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{1'b1, 3'd1, 8'hFE, 1'b0, 8'hFE, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 3'd2, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 3'd2, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1};
        tbl[3]  = '{1'b1, 3'd1, 8'h81, 1'b0, 8'h81, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 3'd4, 8'h55, 1'b0, 8'h02, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 3'd5, 8'hAA, 1'b1, 8'h81, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 3'd6, 8'h00, 1'b0, 8'h03, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 3'd1, 8'h3C, 1'b0, 8'h3C, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 3'd7, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 3'd3, 8'h00, 1'b0, 8'hFF, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 3'd0, 8'h12, 1'b1, 8'hFF, 1'b0, 1'b0};

        nclr = 1'b0; en = 1'b1; mode = 3'd2; d = 8'h00; sin = 1'b0;
        mq_w = 8'h5A; mc_w = 0; mq_s = 0; mc_s = 0;
        #12;
        check_model("reset");
        @(posedge clk);
        #1;
        check_model("reset_held_over_edge");
        #3 nclr = 1'b1;
        #1;
        check_model("release_no_change");

        // Directed vectors on the wrapping instance.
        for (int i = 0; i < 11; i++) begin
            cyc(tbl[i].en, tbl[i].mode, tbl[i].d, tbl[i].sin, $sformatf("tbl%0d", i));
            check($sformatf("tbl%0d_q", i), qw, tbl[i].q);
            check($sformatf("tbl%0d_c", i), cw, tbl[i].c);
            check($sformatf("tbl%0d_z", i), zw, tbl[i].z);
        end

        // Saturating dec at zero, then load clears the flag.
        cyc(1'b1, 3'd7, 8'h00, 1'b0, "sat_clr");
        cyc(1'b1, 3'd3, 8'h00, 1'b0, "sat_dec0");
        check("sat_dec0_q", qs, 8'h00);
        check("sat_dec0_c", cs, 1'b1);
        cyc(1'b1, 3'd1, 8'h01, 1'b0, "sat_load1");
        check("sat_load1_c", cs, 1'b0);

        // en=0 across all modes must freeze q and a set cout.
        cyc(1'b1, 3'd1, 8'hFF, 1'b0, "frz_load");
        cyc(1'b1, 3'd2, 8'h00, 1'b0, "frz_inc");
        check("sat_inc_max_q", qs, 8'hFF);
        check("sat_inc_max_c", cs, 1'b1);
        for (int m = 0; m < 8; m++) begin
            cyc(1'b0, 3'(m), 8'($urandom), 1'($urandom), $sformatf("frz_m%0d", m));
            check($sformatf("frz_m%0d_q", m), qw, 8'h00);
            check($sformatf("frz_m%0d_c", m), cw, 1'b1);
        end

        // Asynchronous clear mid-cycle during an inc run.
        cyc(1'b1, 3'd2, 8'h00, 1'b0, "run_inc0");
        cyc(1'b1, 3'd2, 8'h00, 1'b0, "run_inc1");
        #2 nclr = 1'b0;
        #1;
        mq_w = 8'h5A; mc_w = 0; mq_s = 0; mc_s = 0;
        check("async_q", qw, 8'h5A);
        check("async_c", cw, 1'b0);
        check_model("async");
        #3 nclr = 1'b1;
        #1;
        check_model("async_release");
        cyc(1'b1, 3'd2, 8'h00, 1'b0, "post_rst_inc");
        check("post_rst_inc_q", qw, 8'h5B);

        // Random operations against the model, with occasional resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                #2 nclr = 1'b0;
                #1;
                mq_w = 8'h5A; mc_w = 0; mq_s = 0; mc_s = 0;
                check_model("rnd_rst");
                #1 nclr = 1'b1;
            end
            cyc(1'($urandom_range(0, 7) != 0), 3'($urandom), 8'($urandom),
                1'($urandom), "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
